// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_target_pkg;

  // Protocol phases of the target; each *_ACK state covers the ninth SCL clock.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  // Glitch-filter run counter width; supports FILTER_CYCLES up to 16.
  localparam int FILTER_CNT_W = 4;

  // Bit counter must hold the value 8 (a full byte has been clocked).
  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;

  // Level of SDA during the ninth clock.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one I2C line.
// The filtered level only follows the synchronised level once it has been seen
// on FILTER_CYCLES consecutive clocks. Idle I2C lines are high, so everything
// resets to 1.
module i2c_line_filter
  import i2c_target_pkg::*;
#(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [FILTER_CNT_W-1:0] CNT_LAST = FILTER_CNT_W'(FILTER_CYCLES - 1);

  logic [1:0]              sync_q;
  logic                    filt_q, filt_d;
  logic [FILTER_CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Hold the accepted level and the run counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte-wide register file with an auto-incrementing
// pointer, also reachable by the local processor through an Avalon-MM slave.
// SDA is open-drain: sda_oe=1 pulls the line low.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR      = 7'h39,
  parameter int         NUM_REGS      = 16,
  parameter int         ADDR_W        = 4,
  parameter int         FILTER_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              busy
);

  logic sclFilt, sdaFilt;
  logic sclPrev_q, sdaPrev_q;
  logic sclRise, sclFall, startDet, stopDet;

  state_t               state_q, state_d;
  logic [BIT_CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           tx_q, tx_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic                 rw_q, rw_d;
  logic                 ackBit_q, ackBit_d;
  logic                 sdaOe_q, sdaOe_d;
  logic                 i2cWe;
  logic [7:0]           i2cWdata;

  logic [7:0]           regs_q [NUM_REGS];
  logic [31:0]          readdata_q;
  logic                 hostWe;
  logic                 unusedWriteHi;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sclFilter (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (scl_in),
    .filt_o (sclFilt)
  );

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sdaFilter (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (sda_in),
    .filt_o (sdaFilt)
  );

  // Remember last filtered levels so edges and bus conditions can be spotted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclPrev_q <= sclFilt;
      sdaPrev_q <= sdaFilt;
    end
  end

  assign sclRise  =  sclFilt & ~sclPrev_q;
  assign sclFall  = ~sclFilt &  sclPrev_q;
  assign startDet =  sclFilt &  sclPrev_q &  sdaPrev_q & ~sdaFilt;
  assign stopDet  =  sclFilt &  sclPrev_q & ~sdaPrev_q &  sdaFilt;

  // Protocol sequencing: bits are taken on SCL rise, SDA drive only moves on SCL fall.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    ackBit_d = ackBit_q;
    sdaOe_d  = sdaOe_q;
    i2cWe    = 1'b0;
    i2cWdata = shift_q;

    if (startDet) begin
      state_d  = ST_ADDR;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
    end else if (stopDet) begin
      state_d  = ST_IDLE;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (sclRise) begin
            shift_d  = {shift_q[6:0], sdaFilt};
            bitCnt_d = bitCnt_q + 1'b1;
          end else if (sclFall && bitCnt_q == BITS_PER_BYTE) begin
            bitCnt_d = '0;
            sdaOe_d  = 1'b1;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                rw_d    = shift_q[0];
                state_d = ST_ADDR_ACK;
              end else begin
                sdaOe_d = 1'b0;
                state_d = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d   = shift_q[ADDR_W-1:0];
              state_d = ST_PTR_ACK;
            end else begin
              i2cWe   = 1'b1;
              ptr_d   = ptr_q + 1'b1;
              state_d = ST_WDATA_ACK;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (sclFall) begin
            bitCnt_d = '0;
            sdaOe_d  = 1'b0;
            if (rw_q) begin
              tx_d    = regs_q[ptr_q];
              sdaOe_d = ~regs_q[ptr_q][7];
              state_d = ST_RDATA;
            end else begin
              state_d = ST_PTR;
            end
          end
        end

        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (sclFall) begin
            bitCnt_d = '0;
            sdaOe_d  = 1'b0;
            state_d  = ST_WDATA;
          end
        end

        ST_RDATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 1'b1;
          end else if (sclFall) begin
            if (bitCnt_q == BITS_PER_BYTE) begin
              bitCnt_d = '0;
              sdaOe_d  = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              state_d  = ST_RDATA_ACK;
            end else begin
              tx_d    = {tx_q[6:0], 1'b0};
              sdaOe_d = ~tx_q[6];
            end
          end
        end

        ST_RDATA_ACK: begin
          if (sclRise) begin
            ackBit_d = sdaFilt;
          end else if (sclFall) begin
            bitCnt_d = '0;
            if (ackBit_q == ACK) begin
              tx_d    = regs_q[ptr_q];
              sdaOe_d = ~regs_q[ptr_q][7];
              state_d = ST_RDATA;
            end else begin
              sdaOe_d = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // Protocol state register; reset releases SDA immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      ackBit_q <= NACK;
      sdaOe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      ackBit_q <= ackBit_d;
      sdaOe_q  <= sdaOe_d;
    end
  end

  assign hostWe        = chipselect & ~write_n;
  assign unusedWriteHi = ^writedata[31:8];

  // Register file: the host write takes priority when both sides hit the same byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hostWe && address == ADDR_W'(i)) begin
          regs_q[i] <= writedata[7:0];
        end else if (i2cWe && ptr_q == ADDR_W'(i)) begin
          regs_q[i] <= i2cWdata;
        end
      end
    end
  end

  // Host read path, refreshed every clock regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= {24'b0, regs_q[address]};
    end
  end

  assign readdata = readdata_q;
  assign sda_oe   = sdaOe_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-banged initiator plus Avalon host drive
// the target while a scoreboard compares observed bytes/ACKs/flags against a
// register-array model of the device.
module tb_i2c_target_regfile;

  localparam int Q      = 8;
  localparam int K_RD   = 0;
  localparam int K_I2C  = 1;
  localparam int K_BUSY = 2;
  localparam int K_OE   = 3;
  localparam int K_FLAG = 4;

  logic        clk;
  logic        reset_n;
  logic        mScl, mSda;
  logic        sclIn, sdaIn;
  logic        sda_oe;
  logic [3:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic        busy;

  logic [7:0]  mRegs [16];
  int          mPtr;
  logic [7:0]  txBytes [$];

  string       tagQ [$];
  logic [31:0] valQ [$];
  logic        probeReq;
  int          probeKind;
  logic [7:0]  i2cObs;
  logic        sawBusy;
  int          errors;
  int          checks;

  assign sclIn = mScl;
  assign sdaIn = mSda & ~sda_oe;

  i2c_target_regfile dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (sclIn),
    .sda_in    (sdaIn),
    .sda_oe    (sda_oe),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: pops one expectation each time a DUT output is presented.
  always @(negedge clk) begin
    if (probeReq) begin
      logic [31:0] act;
      logic [31:0] exp;
      string       tag;
      case (probeKind)
        K_RD:    act = readdata;
        K_I2C:   act = {24'b0, i2cObs};
        K_BUSY:  act = {31'b0, busy};
        K_OE:    act = {31'b0, sda_oe};
        default: act = {31'b0, sawBusy};
      endcase
      checks++;
      if (tagQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_empty: got 0x%0h, no expectation queued", act);
      end else begin
        tag = tagQ.pop_front();
        exp = valQ.pop_front();
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
      end
    end
  end

  task automatic checkOutput(input int kind, input string tag, input logic [31:0] exp);
    #1;
    tagQ.push_back(tag);
    valQ.push_back(exp);
    probeKind = kind;
    probeReq  = 1'b1;
    @(negedge clk);
    #1;
    probeReq = 1'b0;
  endtask

  task automatic waitQ();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic clockBit(input logic b, output logic s);
    mSda = b;
    waitQ();
    mScl = 1'b1;
    waitQ();
    s = sdaIn;
    waitQ();
    mScl = 1'b0;
    waitQ();
  endtask

  task automatic i2cStart();
    mSda = 1'b1;
    waitQ();
    mScl = 1'b1;
    waitQ();
    mSda = 1'b0;
    waitQ();
    mScl = 1'b0;
    waitQ();
  endtask

  task automatic i2cStop();
    mSda = 1'b0;
    waitQ();
    mScl = 1'b1;
    waitQ();
    mSda = 1'b1;
    waitQ();
  endtask

  task automatic sendByte(input logic [7:0] b, input logic expAck, input string tag);
    logic s;
    for (int k = 7; k >= 0; k--) clockBit(b[k], s);
    clockBit(1'b1, s);
    i2cObs = {7'b0, s};
    checkOutput(K_I2C, tag, {31'b0, expAck});
  endtask

  task automatic recvByte(input logic masterAck, input logic [7:0] exp, input string tag);
    logic       s;
    logic [7:0] got;
    got = '0;
    for (int k = 7; k >= 0; k--) begin
      clockBit(1'b1, s);
      got[k] = s;
    end
    i2cObs = got;
    clockBit(masterAck, s);
    checkOutput(K_I2C, tag, {24'b0, exp});
  endtask

  task automatic avWrite(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    mRegs[a]   = d[7:0];
  endtask

  task automatic avRead(input logic [3:0] a, input string tag);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput(K_RD, tag, {24'b0, mRegs[a]});
    chipselect = 1'b0;
  endtask

  task automatic i2cWriteTxn(input logic [7:0] p);
    i2cStart();
    sendByte(8'h72, 1'b0, "addr_w_ack");
    checkOutput(K_BUSY, "busy_active", 32'd1);
    sendByte(p, 1'b0, "ptr_ack");
    mPtr = int'(p) % 16;
    foreach (txBytes[k]) begin
      sendByte(txBytes[k], 1'b0, "wdata_ack");
      mRegs[mPtr] = txBytes[k];
      mPtr = (mPtr + 1) % 16;
    end
    i2cStop();
    checkOutput(K_BUSY, "busy_after_stop", 32'd0);
  endtask

  task automatic i2cReadTxn(input logic setPtr, input logic [7:0] p, input int n);
    logic [7:0] exp;
    i2cStart();
    if (setPtr) begin
      sendByte(8'h72, 1'b0, "addr_w_ack");
      sendByte(p, 1'b0, "ptr_ack");
      mPtr = int'(p) % 16;
      i2cStart();
    end
    sendByte(8'h73, 1'b0, "addr_r_ack");
    for (int k = 0; k < n; k++) begin
      exp  = mRegs[mPtr];
      mPtr = (mPtr + 1) % 16;
      recvByte((k == n - 1) ? 1'b1 : 1'b0, exp, "rdata");
    end
    checkOutput(K_OE, "oe_after_nack", 32'd0);
    i2cStop();
    checkOutput(K_BUSY, "busy_after_stop", 32'd0);
  endtask

  task automatic missTxn(input logic [6:0] a);
    i2cStart();
    sendByte({a, 1'b0}, 1'b1, "miss_addr_noack");
    sendByte(8'($urandom_range(0, 255)), 1'b1, "miss_data_noack");
    checkOutput(K_OE, "miss_oe", 32'd0);
    i2cStop();
    checkOutput(K_BUSY, "busy_after_stop", 32'd0);
  endtask

  task automatic sdaPulse(input int len, input logic expDetect, input string tag);
    @(posedge clk);
    #1;
    sawBusy = 1'b0;
    mSda = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    mSda = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
    end
    checkOutput(K_FLAG, tag, {31'b0, expDetect});
    checkOutput(K_BUSY, "busy_after_pulse", 32'd0);
  endtask

  task automatic applyStimulus(input int op);
    logic [6:0] a;
    int         n;
    n = int'($urandom_range(1, 3));
    case (op)
      0: begin
        txBytes.delete();
        for (int k = 0; k < n; k++) txBytes.push_back(8'($urandom_range(0, 255)));
        i2cWriteTxn(8'($urandom_range(0, 255)));
      end
      1: i2cReadTxn(1'b1, 8'($urandom_range(0, 255)), n);
      2: i2cReadTxn(1'b0, 8'h00, n);
      3: avWrite(4'($urandom_range(0, 15)), $urandom);
      4: begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h39) a = 7'h38;
        missTxn(a);
      end
      default: avRead(4'($urandom_range(0, 15)), "rand_avread");
    endcase
  endtask

  initial begin
    logic s;
    errors     = 0;
    checks     = 0;
    probeReq   = 1'b0;
    probeKind  = 0;
    i2cObs     = '0;
    sawBusy    = 1'b0;
    reset_n    = 1'b0;
    mScl       = 1'b1;
    mSda       = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    mPtr       = 0;
    for (int i = 0; i < 16; i++) mRegs[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    checkOutput(K_OE, "reset_oe", 32'd0);
    checkOutput(K_BUSY, "reset_busy", 32'd0);
    checkOutput(K_RD, "reset_readdata", 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] directed write");
    txBytes.delete();
    txBytes.push_back(8'hA5);
    txBytes.push_back(8'h5A);
    i2cWriteTxn(8'h03);
    avRead(4'd3, "reg3");
    avRead(4'd4, "reg4");

    $display("[TB] directed read with repeated start");
    avWrite(4'd7, 32'hFFFF_FF3C);
    avWrite(4'd8, 32'h0000_00C3);
    i2cReadTxn(1'b1, 8'h07, 2);

    $display("[TB] address miss");
    missTxn(7'h28);
    avRead(4'd3, "reg3_after_miss");

    $display("[TB] pointer wrap");
    txBytes.delete();
    txBytes.push_back(8'h11);
    txBytes.push_back(8'h22);
    i2cWriteTxn(8'h0F);
    avRead(4'd15, "reg15_wrap");
    avRead(4'd0, "reg0_wrap");

    $display("[TB] glitch filter");
    sdaPulse(1, 1'b0, "glitch_1cyc_ignored");
    sdaPulse(4, 1'b1, "glitch_4cyc_detected");

    $display("[TB] random traffic");
    for (int t = 0; t < 16; t++) applyStimulus(int'($urandom_range(0, 5)));
    for (int i = 0; i < 16; i++) avRead(4'(i), "scan");

    $display("[TB] reset abort mid-read");
    avWrite(4'd5, 32'h0000_0000);
    i2cStart();
    sendByte(8'h72, 1'b0, "abort_addr_w");
    sendByte(8'h05, 1'b0, "abort_ptr");
    i2cStart();
    sendByte(8'h73, 1'b0, "abort_addr_r");
    clockBit(1'b1, s);
    checkOutput(K_OE, "abort_oe_driving", 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    checkOutput(K_OE, "abort_oe_released", 32'd0);
    checkOutput(K_BUSY, "abort_busy", 32'd0);
    mScl = 1'b1;
    mSda = 1'b1;
    for (int i = 0; i < 16; i++) mRegs[i] = 8'h00;
    mPtr = 0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    avRead(4'd5, "abort_reg5");
    avRead(4'd3, "abort_reg3");

    if (tagQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", tagQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
